// File: rtl/decode_queue_if.sv
// Decoded-instruction types shared by the decode queue and its consumers,
// plus the fetch/execute-facing bus of the queue.
package decode_queue_pkg;
  typedef enum logic [3:0] {
    ALU_OP_NONE, ALU_OP_PLUS, ALU_OP_MINUS, ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR,
    ALU_OP_NOR, ALU_OP_SLT, ALU_OP_SLTU, ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA, ALU_OP_LUI
  } alu_op_t;
  typedef enum logic       {SRC_A_RS, SRC_A_RT} src_a_t;
  typedef enum logic [2:0] {SRC_B_ZERO, SRC_B_RT, SRC_B_IMM_SX, SRC_B_IMM_ZX, SRC_B_SA, SRC_B_RS} src_b_t;
  typedef enum logic [1:0] {REG_DST_NONE, REG_DST_RD, REG_DST_RT, REG_DST_RA} reg_dst_t;
  typedef enum logic [2:0] {VAL_NONE, VAL_ALU, VAL_MEM, VAL_PC8, VAL_HI, VAL_LO} val_t;
  typedef enum logic [3:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LEZ, BR_GTZ, BR_LTZ, BR_GEZ, BR_J, BR_JR
  } branch_t;
  typedef enum logic [3:0] {
    MEM_NONE, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW
  } mem_t;
  typedef enum logic [2:0] {
    HILO_NONE, HILO_MULT, HILO_MULTU, HILO_DIV, HILO_DIVU, HILO_MTHI, HILO_MTLO
  } hilo_t;

  typedef struct packed {
    alu_op_t  alu_op;
    src_a_t   alu_src_a;
    src_b_t   alu_src_b;
    reg_dst_t reg_dst;
    logic     reg_write_en;
    val_t     val;
    branch_t  branch;
    mem_t     mem;
    hilo_t    hilo;
  } control_t;

  localparam control_t CTRL_NOP = '0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    control_t    ctrl;
    logic        ds;
    logic        ri;
    logic        sys;
    logic        brk;
    logic [1:0]  cp0;
    logic        ov;
  } entry_t;
endpackage

interface decode_queue_if #(parameter int DEPTH = 4);
  logic                      in_valid, in_ready;
  logic [31:0]               in_instr, in_pc;
  logic                      flush;
  logic                      out_valid, out_ready;
  logic [31:0]               out_instr, out_pc;
  decode_queue_pkg::control_t out_control;
  logic                      out_delay_slot, out_exc_ri, out_exc_syscall, out_exc_break;
  logic [1:0]                out_cp0;
  logic                      out_ov_check;
  logic [$clog2(DEPTH):0]    count;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_control, out_delay_slot,
           out_exc_ri, out_exc_syscall, out_exc_break, out_cp0, out_ov_check, count
  );
  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_control, out_delay_slot,
           out_exc_ri, out_exc_syscall, out_exc_break, out_cp0, out_ov_check, count
  );
endinterface

// File: rtl/decode_queue.sv
// MIPS decode stage: decodes on enqueue, buffers DEPTH entries in order,
// tags delay slots and exception classes for execute.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter bit EXC_EN = 1'b1
) (
  input logic           clk,
  input logic           reset,
  decode_queue_if.slave q
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   cnt;
  logic          last_br;
  logic          enq, deq;

  logic [5:0] op, fn;
  logic [4:0] rs, rt;
  assign op = q.in_instr[31:26];
  assign rs = q.in_instr[25:21];
  assign rt = q.in_instr[20:16];
  assign fn = q.in_instr[5:0];

  control_t   c;
  logic       ri, sys, brk, ov, link, ld, st;
  logic [1:0] cp0;
  always_comb begin
    c = CTRL_NOP;
    {ri, sys, brk, ov, link, ld, st} = '0;
    cp0 = 2'b00;
    case (op)
      6'h00: begin
        c.reg_dst = REG_DST_RD; c.reg_write_en = 1'b1; c.val = VAL_ALU; c.alu_src_b = SRC_B_RT;
        case (fn)
          6'h00: begin c.alu_op = ALU_OP_SLL; c.alu_src_a = SRC_A_RT; c.alu_src_b = SRC_B_SA; end
          6'h02: begin c.alu_op = ALU_OP_SRL; c.alu_src_a = SRC_A_RT; c.alu_src_b = SRC_B_SA; end
          6'h03: begin c.alu_op = ALU_OP_SRA; c.alu_src_a = SRC_A_RT; c.alu_src_b = SRC_B_SA; end
          6'h04: begin c.alu_op = ALU_OP_SLL; c.alu_src_a = SRC_A_RT; c.alu_src_b = SRC_B_RS; end
          6'h06: begin c.alu_op = ALU_OP_SRL; c.alu_src_a = SRC_A_RT; c.alu_src_b = SRC_B_RS; end
          6'h07: begin c.alu_op = ALU_OP_SRA; c.alu_src_a = SRC_A_RT; c.alu_src_b = SRC_B_RS; end
          6'h08: begin c = CTRL_NOP; c.branch = BR_JR; end
          6'h09: begin c.alu_src_b = SRC_B_ZERO; c.branch = BR_JR; c.val = VAL_PC8; end
          6'h0C: begin c = CTRL_NOP; sys = 1'b1; end
          6'h0D: begin c = CTRL_NOP; brk = 1'b1; end
          6'h10: begin c.alu_src_b = SRC_B_ZERO; c.val = VAL_HI; end
          6'h12: begin c.alu_src_b = SRC_B_ZERO; c.val = VAL_LO; end
          6'h11: begin c = CTRL_NOP; c.hilo = HILO_MTHI; end
          6'h13: begin c = CTRL_NOP; c.hilo = HILO_MTLO; end
          6'h18: begin c = CTRL_NOP; c.alu_src_b = SRC_B_RT; c.hilo = HILO_MULT;  end
          6'h19: begin c = CTRL_NOP; c.alu_src_b = SRC_B_RT; c.hilo = HILO_MULTU; end
          6'h1A: begin c = CTRL_NOP; c.alu_src_b = SRC_B_RT; c.hilo = HILO_DIV;   end
          6'h1B: begin c = CTRL_NOP; c.alu_src_b = SRC_B_RT; c.hilo = HILO_DIVU;  end
          6'h20: begin c.alu_op = ALU_OP_PLUS;  ov = 1'b1; end
          6'h21: c.alu_op = ALU_OP_PLUS;
          6'h22: begin c.alu_op = ALU_OP_MINUS; ov = 1'b1; end
          6'h23: c.alu_op = ALU_OP_MINUS;
          6'h24: c.alu_op = ALU_OP_AND;
          6'h25: c.alu_op = ALU_OP_OR;
          6'h26: c.alu_op = ALU_OP_XOR;
          6'h27: c.alu_op = ALU_OP_NOR;
          6'h2A: c.alu_op = ALU_OP_SLT;
          6'h2B: c.alu_op = ALU_OP_SLTU;
          default: begin c = CTRL_NOP; ri = 1'b1; end
        endcase
      end
      6'h01: begin
        case (rt)
          5'h00: c.branch = BR_LTZ;
          5'h01: c.branch = BR_GEZ;
          5'h10: begin c.branch = BR_LTZ; link = 1'b1; end
          5'h11: begin c.branch = BR_GEZ; link = 1'b1; end
          default: ri = 1'b1;
        endcase
      end
      6'h02: c.branch = BR_J;
      6'h03: begin c.branch = BR_J; link = 1'b1; end
      6'h04: begin c.branch = BR_EQ; c.alu_src_b = SRC_B_RT; end
      6'h05: begin c.branch = BR_NE; c.alu_src_b = SRC_B_RT; end
      6'h06: c.branch = BR_LEZ;
      6'h07: c.branch = BR_GTZ;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        c.reg_dst = REG_DST_RT; c.reg_write_en = 1'b1; c.val = VAL_ALU; c.alu_src_b = SRC_B_IMM_SX;
        case (op[2:0])
          3'd0: begin c.alu_op = ALU_OP_PLUS; ov = 1'b1; end
          3'd1: c.alu_op = ALU_OP_PLUS;
          3'd2: c.alu_op = ALU_OP_SLT;
          3'd3: c.alu_op = ALU_OP_SLTU;
          3'd4: begin c.alu_op = ALU_OP_AND; c.alu_src_b = SRC_B_IMM_ZX; end
          3'd5: begin c.alu_op = ALU_OP_OR;  c.alu_src_b = SRC_B_IMM_ZX; end
          3'd6: begin c.alu_op = ALU_OP_XOR; c.alu_src_b = SRC_B_IMM_ZX; end
          3'd7: begin c.alu_op = ALU_OP_LUI; c.alu_src_b = SRC_B_IMM_ZX; end
        endcase
      end
      6'h10: begin
        if (q.in_instr == 32'h4200_0018) cp0 = 2'b11;
        else if (rs == 5'd0) begin
          // MFC0: writeback swaps in the CP0 value, so no datapath source here
          cp0 = 2'b01; c.reg_write_en = 1'b1; c.reg_dst = REG_DST_RT;
        end else if (rs == 5'd4) begin
          cp0 = 2'b10; c.alu_src_a = SRC_A_RT; c.alu_op = ALU_OP_OR;
        end else ri = 1'b1;
      end
      6'h20: begin ld = 1'b1; c.mem = MEM_LB;  end
      6'h21: begin ld = 1'b1; c.mem = MEM_LH;  end
      6'h23: begin ld = 1'b1; c.mem = MEM_LW;  end
      6'h24: begin ld = 1'b1; c.mem = MEM_LBU; end
      6'h25: begin ld = 1'b1; c.mem = MEM_LHU; end
      6'h28: begin st = 1'b1; c.mem = MEM_SB;  end
      6'h29: begin st = 1'b1; c.mem = MEM_SH;  end
      6'h2B: begin st = 1'b1; c.mem = MEM_SW;  end
      default: ri = 1'b1;
    endcase
    if (link) begin c.reg_dst = REG_DST_RA; c.reg_write_en = 1'b1; c.val = VAL_PC8; end
    if (ld || st) begin c.alu_op = ALU_OP_PLUS; c.alu_src_b = SRC_B_IMM_SX; end
    if (ld) begin c.reg_dst = REG_DST_RT; c.reg_write_en = 1'b1; c.val = VAL_MEM; end
    if (q.in_instr == 32'h0) c = CTRL_NOP;
    if (!EXC_EN && (ri || sys || brk || ov || cp0 != 2'b00)) begin
      c = CTRL_NOP;
      {ri, sys, brk, ov} = '0;
      cp0 = 2'b00;
    end
  end

  entry_t dec;
  always_comb begin
    dec       = '0;
    dec.instr = q.in_instr;
    dec.pc    = q.in_pc;
    dec.ctrl  = c;
    dec.ds    = last_br;
    dec.ri    = ri;
    dec.sys   = sys;
    dec.brk   = brk;
    dec.cp0   = cp0;
    dec.ov    = ov;
  end

  assign q.in_ready  = (cnt != FULL);
  assign q.out_valid = (cnt != '0);
  assign q.count     = cnt;
  assign enq = q.in_valid && q.in_ready && !q.flush;
  assign deq = q.out_valid && q.out_ready && !q.flush;

  always_ff @(posedge clk) begin
    if (reset || q.flush) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      last_br <= 1'b0;
    end else begin
      if (enq) begin
        tail    <= tail + 1'b1;
        last_br <= (c.branch != BR_NONE);
      end
      if (deq) head <= head + 1'b1;
      case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq && !reset) mem_q[tail] <= dec;
  end

  // Empty queue presents an all-zero entry, which is also the nop bundle.
  entry_t hd;
  assign hd = q.out_valid ? mem_q[head] : '0;

  assign q.out_instr       = hd.instr;
  assign q.out_pc          = hd.pc;
  assign q.out_control     = hd.ctrl;
  assign q.out_delay_slot  = hd.ds;
  assign q.out_exc_ri      = hd.ri;
  assign q.out_exc_syscall = hd.sys;
  assign q.out_exc_break   = hd.brk;
  assign q.out_cp0         = hd.cp0;
  assign q.out_ov_check    = hd.ov;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: one DUT with exception decode enabled and
// one with it disabled, both fed the same stimulus.
module tb_decode_queue;
  import decode_queue_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decode_queue_if #(.DEPTH(4)) bi ();
  decode_queue_if #(.DEPTH(4)) b0 ();

  decode_queue #(.DEPTH(4), .EXC_EN(1'b1)) u_dut       (.clk(clk), .reset(reset), .q(bi));
  decode_queue #(.DEPTH(4), .EXC_EN(1'b0)) u_dut_noexc (.clk(clk), .reset(reset), .q(b0));

  assign b0.in_valid  = bi.in_valid;
  assign b0.in_instr  = bi.in_instr;
  assign b0.in_pc     = bi.in_pc;
  assign b0.flush     = bi.flush;
  assign b0.out_ready = bi.out_ready;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p);
    bi.in_valid = 1'b1; bi.in_instr = i; bi.in_pc = p;
    cyc();
    bi.in_valid = 1'b0;
  endtask

  task automatic pop();
    bi.out_ready = 1'b1;
    cyc();
    bi.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bi.in_valid = 1'b1; bi.in_instr = 32'h2408_0005; bi.in_pc = 32'h0;
    bi.flush = 1'b1; bi.out_ready = 1'b0;
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0; bi.in_valid = 1'b0; bi.flush = 1'b0;
    checks++;
    if ({bi.out_valid, bi.in_ready, bi.count} !== {1'b0, 1'b1, 3'd0}) begin
      errors++; $display("FAIL reset_status got %b want 01000", {bi.out_valid, bi.in_ready, bi.count});
    end
    checks++;
    if ({bi.out_instr, bi.out_pc} !== 64'h0) begin
      errors++; $display("FAIL reset_payload got %h want 0", {bi.out_instr, bi.out_pc});
    end
    checks++;
    if (bi.out_control !== CTRL_NOP) begin
      errors++; $display("FAIL reset_control got %h want %h", bi.out_control, CTRL_NOP);
    end
    checks++;
    if ({bi.out_delay_slot, bi.out_exc_ri, bi.out_exc_syscall, bi.out_exc_break, bi.out_cp0, bi.out_ov_check} !== 7'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0",
        {bi.out_delay_slot, bi.out_exc_ri, bi.out_exc_syscall, bi.out_exc_break, bi.out_cp0, bi.out_ov_check});
    end
  endtask

  task automatic test_basic();
    control_t exp;
    exp = CTRL_NOP;
    exp.alu_op = ALU_OP_PLUS; exp.alu_src_b = SRC_B_IMM_SX; exp.reg_dst = REG_DST_RT;
    exp.reg_write_en = 1'b1; exp.val = VAL_ALU;
    bi.in_valid = 1'b1; bi.in_instr = 32'h2408_0005; bi.in_pc = 32'hBFC0_0000;
    #1;
    checks++;
    if (bi.out_valid !== 1'b0) begin
      errors++; $display("FAIL no_bypass got %b want 0", bi.out_valid);
    end
    @(posedge clk); #1;
    bi.in_valid = 1'b0;
    checks++;
    if ({bi.out_valid, bi.count} !== {1'b1, 3'd1}) begin
      errors++; $display("FAIL basic_status got %b want 1001", {bi.out_valid, bi.count});
    end
    checks++;
    if (bi.out_control !== exp) begin
      errors++; $display("FAIL basic_control got %h want %h", bi.out_control, exp);
    end
    checks++;
    if ({bi.out_instr, bi.out_pc} !== {32'h2408_0005, 32'hBFC0_0000}) begin
      errors++; $display("FAIL basic_payload got %h want 24080005bfc00000", {bi.out_instr, bi.out_pc});
    end
    checks++;
    if ({bi.out_delay_slot, bi.out_exc_ri, bi.out_exc_syscall, bi.out_exc_break, bi.out_cp0, bi.out_ov_check} !== 7'b0) begin
      errors++; $display("FAIL basic_flags got %b want 0",
        {bi.out_delay_slot, bi.out_exc_ri, bi.out_exc_syscall, bi.out_exc_break, bi.out_cp0, bi.out_ov_check});
    end
    pop();
    checks++;
    if (bi.count !== 3'd0) begin
      errors++; $display("FAIL basic_drain got %0d want 0", bi.count);
    end
  endtask

  task automatic test_delay_slot();
    logic [31:0] w  [3] = '{32'h1109_0003, 32'h0000_0000, 32'h0109_5021};
    logic        ds [3] = '{1'b0, 1'b1, 1'b0};
    branch_t     br [3] = '{BR_EQ, BR_NONE, BR_NONE};
    for (int i = 0; i < 3; i++) push(w[i], 32'h100 + 32'(4 * i));
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bi.out_instr !== w[i]) begin
        errors++; $display("FAIL ds_order[%0d] got %h want %h", i, bi.out_instr, w[i]);
      end
      checks++;
      if ({bi.out_delay_slot, bi.out_exc_ri} !== {ds[i], 1'b0}) begin
        errors++; $display("FAIL ds_bit[%0d] got %b want %b0", i, {bi.out_delay_slot, bi.out_exc_ri}, ds[i]);
      end
      checks++;
      if (bi.out_control.branch !== br[i]) begin
        errors++; $display("FAIL ds_branch[%0d] got %0d want %0d", i, bi.out_control.branch, br[i]);
      end
      pop();
    end
  endtask

  task automatic test_back_to_back();
    bi.in_valid = 1'b1; bi.in_instr = 32'h2408_0001; bi.in_pc = 32'h200;
    cyc();
    bi.out_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      bi.in_instr = 32'h2408_0001 + 32'(i); bi.in_pc = 32'h200 + 32'(4 * i);
      cyc();
      checks++;
      if ({bi.count, bi.out_pc} !== {3'd1, 32'h200 + 32'(4 * i)}) begin
        errors++; $display("FAIL b2b[%0d] got count %0d pc %h want 1 %h", i, bi.count, bi.out_pc, 32'h200 + 32'(4 * i));
      end
    end
    bi.in_valid = 1'b0;
    cyc();
    bi.out_ready = 1'b0;
    checks++;
    if ({bi.out_valid, bi.count} !== 4'b0) begin
      errors++; $display("FAIL b2b_drain got %b want 0000", {bi.out_valid, bi.count});
    end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 4; i++) push(32'h2408_0010 + 32'(i), 32'h300 + 32'(4 * i));
    checks++;
    if ({bi.count, bi.in_ready} !== {3'd4, 1'b0}) begin
      errors++; $display("FAIL full got %b want 1000", {bi.count, bi.in_ready});
    end
    bi.in_valid = 1'b1; bi.in_instr = 32'h2408_9999; bi.in_pc = 32'h3F0; bi.out_ready = 1'b1;
    #1;
    checks++;
    if (bi.in_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready_comb got %b want 0", bi.in_ready);
    end
    @(posedge clk); #1;
    bi.in_valid = 1'b0; bi.out_ready = 1'b0;
    checks++;
    if ({bi.count, bi.in_ready, bi.out_pc} !== {3'd3, 1'b1, 32'h304}) begin
      errors++; $display("FAIL full_deq got count %0d ready %b pc %h want 3 1 304", bi.count, bi.in_ready, bi.out_pc);
    end
    push(32'h2408_0014, 32'h310);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bi.out_pc !== 32'h304 + 32'(4 * i)) begin
        errors++; $display("FAIL wrap_order[%0d] got %h want %h", i, bi.out_pc, 32'h304 + 32'(4 * i));
      end
      pop();
    end
    checks++;
    if (bi.count !== 3'd0) begin
      errors++; $display("FAIL wrap_drain got %0d want 0", bi.count);
    end
  endtask

  task automatic test_exc();
    logic [31:0] w  [5] = '{32'h0000_000C, 32'h0000_000D, 32'h4200_0018, 32'h4008_6000, 32'hFC00_0000};
    logic [4:0]  fl [5] = '{5'b01000, 5'b00100, 5'b00011, 5'b00001, 5'b10000};
    control_t    ce [5];
    for (int k = 0; k < 5; k++) ce[k] = CTRL_NOP;
    ce[3].reg_write_en = 1'b1; ce[3].reg_dst = REG_DST_RT;
    for (int i = 0; i < 5; i++) begin
      push(w[i], 32'h400 + 32'(4 * i));
      checks++;
      if ({bi.out_exc_ri, bi.out_exc_syscall, bi.out_exc_break, bi.out_cp0} !== fl[i]) begin
        errors++; $display("FAIL exc_flags[%0d] got %b want %b", i,
          {bi.out_exc_ri, bi.out_exc_syscall, bi.out_exc_break, bi.out_cp0}, fl[i]);
      end
      checks++;
      if (bi.out_control !== ce[i]) begin
        errors++; $display("FAIL exc_control[%0d] got %h want %h", i, bi.out_control, ce[i]);
      end
      checks++;
      if ({b0.out_valid, b0.out_exc_ri, b0.out_exc_syscall, b0.out_exc_break, b0.out_cp0, b0.out_ov_check} !== 7'b1000000) begin
        errors++; $display("FAIL noexc_flags[%0d] got %b want 1000000", i,
          {b0.out_valid, b0.out_exc_ri, b0.out_exc_syscall, b0.out_exc_break, b0.out_cp0, b0.out_ov_check});
      end
      checks++;
      if (b0.out_control !== CTRL_NOP) begin
        errors++; $display("FAIL noexc_control[%0d] got %h want %h", i, b0.out_control, CTRL_NOP);
      end
      pop();
    end
  endtask

  task automatic test_ov();
    logic [31:0] w  [4] = '{32'h0109_5020, 32'h2128_FFFF, 32'h0109_5021, 32'h0109_5022};
    logic        ov [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    alu_op_t     op [4] = '{ALU_OP_PLUS, ALU_OP_PLUS, ALU_OP_PLUS, ALU_OP_MINUS};
    for (int i = 0; i < 4; i++) begin
      push(w[i], 32'h480 + 32'(4 * i));
      checks++;
      if ({bi.out_ov_check, bi.out_exc_ri} !== {ov[i], 1'b0}) begin
        errors++; $display("FAIL ov[%0d] got %b want %b0", i, {bi.out_ov_check, bi.out_exc_ri}, ov[i]);
      end
      checks++;
      if (bi.out_control.alu_op !== op[i]) begin
        errors++; $display("FAIL ov_aluop[%0d] got %0d want %0d", i, bi.out_control.alu_op, op[i]);
      end
      pop();
    end
  endtask

  task automatic test_flush();
    push(32'h0C00_0100, 32'h500);
    checks++;
    if ({bi.out_control.branch, bi.out_control.reg_dst, bi.out_control.val} !== {BR_J, REG_DST_RA, VAL_PC8}) begin
      errors++; $display("FAIL jal_control got %h want %h", bi.out_control, {BR_J, REG_DST_RA, VAL_PC8});
    end
    bi.in_valid = 1'b1; bi.in_instr = 32'h0109_5021; bi.in_pc = 32'h504;
    bi.flush = 1'b1; bi.out_ready = 1'b1;
    cyc();
    bi.in_valid = 1'b0; bi.flush = 1'b0; bi.out_ready = 1'b0;
    checks++;
    if ({bi.count, bi.out_valid, bi.out_instr} !== {3'd0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL flush got count %0d valid %b instr %h want 0 0 0", bi.count, bi.out_valid, bi.out_instr);
    end
    push(32'h0109_5021, 32'h508);
    checks++;
    if ({bi.count, bi.out_pc, bi.out_delay_slot} !== {3'd1, 32'h508, 1'b0}) begin
      errors++; $display("FAIL post_flush got count %0d pc %h ds %b want 1 508 0", bi.count, bi.out_pc, bi.out_delay_slot);
    end
    for (int i = 0; i < 3; i++) push(32'h1109_0003, 32'h50C + 32'(4 * i));
    bi.flush = 1'b1;
    cyc();
    bi.flush = 1'b0;
    checks++;
    if ({bi.count, bi.in_ready} !== {3'd0, 1'b1}) begin
      errors++; $display("FAIL flush_full got %b want 0001", {bi.count, bi.in_ready});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_delay_slot();
    test_back_to_back();
    test_full_wrap();
    test_exc();
    test_ov();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_queue.md
# decode_queue

Buffered, parametrised MIPS decode stage between fetch and execute. Accepts fetched instruction/PC pairs over a valid/ready handshake and decodes each into the `control_t` bundle from `mycpu/control.svh` on enqueue. Decoded entries are stored in a DEPTH-entry FIFO and presented in order to execute. Beyond the existing decode, it tags branch delay slots, flags reserved instructions, SYSCALL/BREAK, COP0 operations and overflow-checked arithmetic, and supports a single-cycle flush.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- EXC_EN, 1, 1: decode SYSCALL/BREAK/COP0/RI/overflow flags; 0: all such encodings decode as nop with every flag 0
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  queue accepts; equals count < DEPTH; no combinational path from out_ready
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- flush  in  1  discard all entries and delay-slot state
- out_valid  out  1  head entry valid
- out_ready  in  1  execute consumes head
- out_instr  out  32  head instruction word
- out_pc  out  32  head PC
- out_control  out  control_t  decoded bundle of head
- out_delay_slot  out  1  head sits in a branch/jump delay slot
- out_exc_ri  out  1  reserved instruction
- out_exc_syscall  out  1  SYSCALL
- out_exc_break  out  1  BREAK
- out_cp0  out  2  00 none, 01 MFC0, 10 MTC0, 11 ERET
- out_ov_check  out  1  ADD/ADDI/SUB: execute must trap on signed overflow
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Enqueue when in_valid && in_ready && !flush. Dequeue when out_valid && out_ready && !flush. Both may occur in the same cycle; count is then unchanged.
- Decode is combinational on in_instr at enqueue; the registered result is stored with instr, PC and the delay-slot bit.
- Decode covers the existing integer set: ALU R/I types, shifts, MULT/DIV/HILO moves, branches including REGIMM and link forms, J/JAL/JR/JALR, and loads/stores. Added encodings:
  - ADD (funct 0x20), SUB (0x22), ADDI (op 0x08): ALU_OP_PLUS / ALU_OP_MINUS / ALU_OP_PLUS, out_ov_check=1.
  - SYSCALL (funct 0x0C), BREAK (0x0D): nop control, corresponding flag.
  - op 0x10: rs=0 gives MFC0, with reg_write_en=1, REG_DST_RT, VAL_NONE; writeback substitutes the CP0 value. rs=4 gives MTC0, with reg_write_en=0 and alu_src_a=RT passed through ALU_OP_OR. The exact word 0x42000018 gives ERET. Any other op 0x10 encoding is RI.
- Any unlisted opcode, funct or REGIMM rt is RI: out_exc_ri=1 with nop control. Word 0x00000000 is a legal nop, not RI.
- Delay-slot tracking: a register last_br is set on enqueue of any entry with branch ≠ BR_NONE and cleared on enqueue of any other entry. The enqueued entry's delay-slot bit equals last_br before the update.
- flush clears head/tail pointers, count and last_br in that cycle. Any simultaneous in_valid or out_ready is ignored.
- When out_valid=0: out_control is the nop bundle, all flags are 0, and out_instr/out_pc are 0.

## Timing
- Reset values: count=0, out_valid=0, in_ready=1, last_br=0, pointers 0; all payload outputs are as when out_valid=0.
- Latency: an entry enqueued in cycle N is visible at the head in N+1 at the earliest. There is no same-cycle bypass through an empty queue.
- Throughput: 1 entry/cycle sustained with out_ready held high.
- Full (count=DEPTH): in_ready=0 even if out_ready=1 in the same cycle. in_ready rises the cycle after a dequeue.
- Pointers wrap modulo DEPTH; count spans 0..DEPTH.
- reset and flush take effect at the clock edge. reset has priority over flush. Both are legal mid-stream, including when full.

## Test plan
- Reset, then enqueue 0x24080005 (ADDIU $t0,$zero,5) at PC 0xBFC00000 → next cycle out_valid=1, ALU_OP_PLUS, REG_DST_RT, count=1, no flags.
- Stream BEQ (0x11090003) then 0x00000000 then ADDU → delay-slot bits 0,1,0; the nop entry is not RI.
- Fill DEPTH=4 with out_ready=0 → in_ready=0 at count=4. Assert out_ready and in_valid together → one dequeue and no enqueue, count=3 next cycle, in_ready=1. Entries exit in order across pointer wrap.
- Enqueue 0x0000000C, 0x0000000D, 0x42000018, 0x40086000, 0xFC000000 → syscall, break, out_cp0=11, out_cp0=01, RI respectively. Repeat with EXC_EN=0 → RI/SYSCALL/BREAK/out_cp0 flags all 0 and control nop for all five.
- ADD 0x01095020 and ADDI 0x2128FFFF → out_ov_check=1; ADDU 0x01095021 → 0.
- Enqueue JAL, then assert flush with in_valid=1 in the same cycle → count=0, out_valid=0 next cycle. The next enqueued entry has delay-slot bit 0.
